// File: rtl/timer_dev_if.sv
// Bus port of timer_dev: CPU-side register access plus the interrupt line.
// The CPU owns addr/we/byteen/wdata; the device drives rdata and irq.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr, we, byteen, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, we, byteen, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/timer_dev.sv
// Down-counting timer with CTRL/PRESET/COUNT registers and a level or pulsed interrupt.
// Mode 0 stops after one expiry with irq held; mode 1 auto-reloads with a one-cycle irq pulse.
module timer_dev (
  input  logic       clk,
  input  logic       reset,
  timer_dev_if.slave bus
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_ctrl;
  logic [3:0]  w_ctrl_next;
  logic [31:0] r_preset;
  logic [31:0] w_preset_merged;
  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic        r_irq_flag;

  logic        w_enable;
  logic [1:0]  w_mode;
  logic        w_im;
  logic        w_ctrl_wr;
  logic        w_preset_wr;
  logic        w_flag_set;
  logic        w_flag_clr;
  logic        w_en_clr;

  assign w_enable = r_ctrl[0];
  assign w_mode   = r_ctrl[2:1];
  assign w_im     = r_ctrl[3];

  assign w_ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL)   && (|bus.byteen);
  assign w_preset_wr = bus.we && (bus.addr == ADDR_PRESET) && (|bus.byteen);

  // Per-lane merge of the write data into PRESET.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_preset_lane
      assign w_preset_merged[8*gi +: 8] = bus.byteen[gi] ? bus.wdata[8*gi +: 8]
                                                         : r_preset[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_flag_set   = 1'b0;
    w_flag_clr   = 1'b0;
    w_en_clr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enable) w_state_next = LOAD;
      end
      LOAD: begin
        w_count_next = r_preset;
        w_state_next = CNT;
      end
      CNT: begin
        if (!w_enable) begin
          w_state_next = IDLE;
        end else if (r_count <= 32'd1) begin
          w_count_next = 32'd0;
          w_flag_set   = 1'b1;
          w_state_next = INT;
        end else begin
          w_count_next = r_count - 32'd1;
        end
      end
      INT: begin
        if (w_mode == 2'd1) begin
          w_flag_clr   = 1'b1;
          w_state_next = LOAD;
        end else begin
          w_en_clr     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A CPU write to the CTRL low byte overrides the FSM's one-shot Enable clear.
  always_comb begin
    w_ctrl_next = r_ctrl;
    if (w_en_clr) w_ctrl_next[0] = 1'b0;
    if (w_ctrl_wr && bus.byteen[0]) w_ctrl_next = bus.wdata[3:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_ctrl  <= w_ctrl_next;
      if (w_preset_wr) r_preset <= w_preset_merged;
      if (w_ctrl_wr || w_preset_wr) r_irq_flag <= 1'b0;
      else if (w_flag_set)          r_irq_flag <= 1'b1;
      else if (w_flag_clr)          r_irq_flag <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      ADDR_CTRL:   bus.rdata = {28'd0, r_ctrl};
      ADDR_PRESET: bus.rdata = r_preset;
      ADDR_COUNT:  bus.rdata = r_count;
      default:     bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = r_irq_flag & w_im;

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 Parameters: none; all register offsets and widths in this document are fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-low; 0 on a rising edge resets the block.
REQ-004 addr  input  2  word offset within the device: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  input  1  bus write strobe; the CPU gates it with interrupt Req.
REQ-006 byteen  input  4  byte-lane enables for writes; bit i covers wdata[8i+7:8i].
REQ-007 wdata  input  32  write data from the CPU data port.
REQ-008 rdata  output  32  combinational read data for addr.
REQ-009 irq  output  1  interrupt request, wired to one HWInt bit of the CPU.

Function
REQ-010 Registers: CTRL[3:0] = {IM, Mode[1:0], Enable}, with CTRL[31:4] reading 0; PRESET[31:0] is read/write; COUNT[31:0] is read-only.
REQ-011 Write: on an edge with we=1, each enabled byte lane of the addressed register takes wdata; unenabled lanes keep their value.
REQ-012 Writes to COUNT, to offset 3 and to CTRL[31:4] are ignored.
REQ-013 Read: rdata = CTRL zero-extended, PRESET, COUNT, or 0 for addr 0, 1, 2, 3 respectively; no added latency.
REQ-014 FSM states: IDLE, LOAD, CNT, INT.
REQ-015 IDLE: COUNT holds its value; go to LOAD when Enable=1.
REQ-016 LOAD: COUNT<=PRESET; go to CNT.
REQ-017 CNT with Enable=0: go to IDLE; COUNT holds.
REQ-018 CNT with Enable=1: if COUNT<=1, set COUNT<=0, set irq_flag<=1 and go to INT; otherwise COUNT<=COUNT-1.
REQ-019 INT with Mode=0 (Mode 2 and 3 behave as Mode 0): clear Enable, go to IDLE; irq_flag stays set.
REQ-020 INT with Mode=1: clear irq_flag, go to LOAD; this gives a one-cycle irq pulse.
REQ-021 irq = irq_flag & IM, as a registered flag gated combinationally.
REQ-022 Latency, PRESET=N>=1: a CTRL write with Enable=1 on edge t gives state LOAD after t+1, COUNT=N after t+2, and COUNT=0 with irq=1 after t+2+N.
REQ-023 Mode 1 period is N+2 cycles between irq pulses.
REQ-024 PRESET=0: same as PRESET=1, i.e. irq after t+3.
REQ-025 Any CTRL or PRESET write (any lane enabled) clears irq_flag on that edge.
REQ-026 Simultaneous events: a bus write to CTRL beats the FSM's Enable clear in INT; the written Enable value wins.
REQ-027 PRESET writes during CNT do not change COUNT; they take effect at the next LOAD.
REQ-028 Clearing Enable mid-count freezes COUNT in IDLE; re-enabling reloads from PRESET and does not resume.
REQ-029 COUNT never wraps below 0.

Reset
REQ-030 reset=0 on an edge sets CTRL=0, PRESET=0, COUNT=0, irq_flag=0 and state IDLE, regardless of state or a concurrent write.
REQ-031 Consequence of REQ-030: irq=0 and rdata reads 0 at every offset in the cycle after reset.
REQ-032 reset asserted mid-count aborts the count, and no irq appears afterwards.

Verification
REQ-033 PRESET<=5, then CTRL<=0x9 (IM=1, Mode 0, Enable) -> COUNT reads 5,4,3,2,1,0; irq rises 7 cycles after the CTRL write; CTRL reads 0x8; irq holds until a CTRL write clears it.
REQ-034 PRESET<=3, CTRL<=0xB (Mode 1) -> a one-cycle irq pulse every 5 cycles; Enable stays 1.
REQ-035 Mode 0 with IM=0, PRESET=2 -> irq stays 0 while irq_flag sets; a later CTRL<=0x8 (IM=1, Enable=0) clears the flag and irq stays 0.
REQ-036 During CNT with COUNT=10, write CTRL<=0x8 -> COUNT freezes at 9 or 10 per edge alignment; CTRL<=0x9 reloads PRESET.
REQ-037 Write PRESET with byteen=0011 and wdata=0xAABBCCDD over 0x11223344 -> PRESET reads 0x1122CCDD; a write to COUNT leaves it unchanged.
REQ-038 Drive reset=0 mid-count with IM=1 -> next cycle all registers read 0 and irq=0, and no irq follows over 20 cycles.
